ibex_ex_issue_ctrl: RTL and testbench

IBEX_EX_ISSUE_CTRL -- requirements
Module: ibex_ex_issue_ctrl

---
 rtl/ibex_ex_issue_ctrl.sv | 145 ++++++++++++++
 tb/tb_ibex_ex_issue_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_ex_issue_ctrl.sv
// EX-stage issue/writeback controller: IDLE -> EXEC -> WB handshake with intermediate-value storage.
// Optional EXEC watchdog enabled by defining IBEX_EX_ISSUE_TIMEOUT_EN (aborts with wb_err_o after TimeoutCycles).
module ibex_ex_issue_ctrl #(
    parameter int unsigned TimeoutCycles = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             issue_valid_i,
    input  logic [1:0]       issue_op_i,
    output logic             issue_ready_o,
    output logic             alu_instr_first_cycle_o,
    output logic             mult_en_o,
    output logic             div_en_o,
    output logic             mult_sel_o,
    output logic             div_sel_o,
    output logic             multdiv_ready_id_o,
    input  logic [1:0]       imd_val_we_i,
    input  logic [1:0][33:0] imd_val_d_i,
    output logic [1:0][33:0] imd_val_q_o,
    input  logic             ex_valid_i,
    input  logic [31:0]      result_ex_i,
    output logic             wb_valid_o,
    output logic [31:0]      wb_result_o,
    output logic             wb_err_o,
    input  logic             wb_ready_i,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        WB   = 2'b10
    } state_e;

    localparam logic [1:0] OpMul = 2'b10;
    localparam logic [1:0] OpDiv = 2'b11;

    if (TimeoutCycles < 2 || TimeoutCycles > 256) begin : g_bad_timeout
        $error("TimeoutCycles must be in 2..256");
    end

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic             first_q, first_d;
    logic [1:0][33:0] imd_q, imd_d;
    logic [31:0]      wb_result_q, wb_result_d;
    logic             accept;

`ifdef IBEX_EX_ISSUE_TIMEOUT_EN
    // Counter saturates the 8-bit range exactly when TimeoutCycles is 256.
    localparam logic [7:0] TimeoutLast = 8'(TimeoutCycles - 1);
    logic [7:0] cnt_q, cnt_d;
    logic       wb_err_q, wb_err_d;
`endif

    assign issue_ready_o = (state_q == IDLE) || ((state_q == WB) && wb_ready_i);
    assign accept        = issue_valid_i && issue_ready_o;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        first_d     = 1'b0;
        imd_d       = imd_q;
        wb_result_d = wb_result_q;
`ifdef IBEX_EX_ISSUE_TIMEOUT_EN
        cnt_d       = cnt_q;
        wb_err_d    = wb_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) state_d = EXEC;
            end
            EXEC: begin
                for (int k = 0; k < 2; k++) begin
                    if (imd_val_we_i[k]) imd_d[k] = imd_val_d_i[k];
                end
                if (ex_valid_i) begin
                    state_d     = WB;
                    wb_result_d = result_ex_i;
`ifdef IBEX_EX_ISSUE_TIMEOUT_EN
                    wb_err_d    = 1'b0;
                end else if (cnt_q == TimeoutLast) begin
                    state_d     = WB;
                    wb_result_d = 32'd0;
                    wb_err_d    = 1'b1;
                end else begin
                    cnt_d       = cnt_q + 8'd1;
`endif
                end
            end
            WB: begin
                if (wb_ready_i) state_d = issue_valid_i ? EXEC : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            op_d    = issue_op_i;
            first_d = 1'b1;
`ifdef IBEX_EX_ISSUE_TIMEOUT_EN
            cnt_d   = 8'd0;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            op_q        <= 2'b00;
            first_q     <= 1'b0;
            imd_q       <= '0;
            wb_result_q <= 32'd0;
`ifdef IBEX_EX_ISSUE_TIMEOUT_EN
            cnt_q       <= 8'd0;
            wb_err_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            first_q     <= first_d;
            imd_q       <= imd_d;
            wb_result_q <= wb_result_d;
`ifdef IBEX_EX_ISSUE_TIMEOUT_EN
            cnt_q       <= cnt_d;
            wb_err_q    <= wb_err_d;
`endif
        end
    end

    assign alu_instr_first_cycle_o = first_q;
    assign multdiv_ready_id_o      = (state_q == EXEC);
    assign mult_en_o               = (state_q == EXEC) && (op_q == OpMul);
    assign div_en_o                = (state_q == EXEC) && (op_q == OpDiv);
    assign mult_sel_o              = (state_q != IDLE) && (op_q == OpMul);
    assign div_sel_o               = (state_q != IDLE) && (op_q == OpDiv);
    assign wb_valid_o              = (state_q == WB);
    assign busy_o                  = (state_q != IDLE);
    assign imd_val_q_o             = imd_q;
    assign wb_result_o             = wb_result_q;
`ifdef IBEX_EX_ISSUE_TIMEOUT_EN
    assign wb_err_o                = wb_err_q;
`else
    assign wb_err_o                = 1'b0;
`endif

endmodule

// File: tb/tb_ibex_ex_issue_ctrl.sv
// Directed bench for ibex_ex_issue_ctrl: vector table plus hand-written multi-cycle sequences.
module tb_ibex_ex_issue_ctrl;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             issue_valid_i;
    logic [1:0]       issue_op_i;
    logic             issue_ready_o;
    logic             alu_instr_first_cycle_o;
    logic             mult_en_o, div_en_o, mult_sel_o, div_sel_o;
    logic             multdiv_ready_id_o;
    logic [1:0]       imd_val_we_i;
    logic [1:0][33:0] imd_val_d_i;
    logic [1:0][33:0] imd_val_q_o;
    logic             ex_valid_i;
    logic [31:0]      result_ex_i;
    logic             wb_valid_o;
    logic [31:0]      wb_result_o;
    logic             wb_err_o;
    logic             wb_ready_i;
    logic             busy_o;

    int checks = 0;
    int errors = 0;

    ibex_ex_issue_ctrl #(.TimeoutCycles(64)) dut (
        .clk_i                   (clk_i),
        .rst_i                   (rst_i),
        .issue_valid_i           (issue_valid_i),
        .issue_op_i              (issue_op_i),
        .issue_ready_o           (issue_ready_o),
        .alu_instr_first_cycle_o (alu_instr_first_cycle_o),
        .mult_en_o               (mult_en_o),
        .div_en_o                (div_en_o),
        .mult_sel_o              (mult_sel_o),
        .div_sel_o               (div_sel_o),
        .multdiv_ready_id_o      (multdiv_ready_id_o),
        .imd_val_we_i            (imd_val_we_i),
        .imd_val_d_i             (imd_val_d_i),
        .imd_val_q_o             (imd_val_q_o),
        .ex_valid_i              (ex_valid_i),
        .result_ex_i             (result_ex_i),
        .wb_valid_o              (wb_valid_o),
        .wb_result_o             (wb_result_o),
        .wb_err_o                (wb_err_o),
        .wb_ready_i              (wb_ready_i),
        .busy_o                  (busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Control-bit order: ready, first, mul_en, div_en, mul_sel, div_sel, md_ready, wb_valid, busy, err
    function automatic logic [9:0] ctrl();
        return {issue_ready_o, alu_instr_first_cycle_o, mult_en_o, div_en_o, mult_sel_o,
                div_sel_o, multdiv_ready_id_o, wb_valid_o, busy_o, wb_err_o};
    endfunction

    localparam logic [9:0] C_IDLE = 10'b1000000000;

    typedef struct {
        logic        chk;
        logic        chk_res;
        logic        rst;
        logic        iv;
        logic [1:0]  op;
        logic        exv;
        logic [31:0] res;
        logic        wbr;
        logic [1:0]  we;
        logic [33:0] d0;
        logic [33:0] d1;
        logic [9:0]  e_ctrl;
        logic [31:0] e_res;
        logic [33:0] e_q0;
        logic [33:0] e_q1;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic iv, input logic [1:0] op, input logic exv,
                         input logic [31:0] res, input logic wbr, input logic [1:0] we,
                         input logic [33:0] d0, input logic [33:0] d1);
        rst_i          = rst;
        issue_valid_i  = iv;
        issue_op_i     = op;
        ex_valid_i     = exv;
        result_ex_i    = res;
        wb_ready_i     = wbr;
        imd_val_we_i   = we;
        imd_val_d_i[0] = d0;
        imd_val_d_i[1] = d1;
    endtask

    task automatic to_next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    int cnt;
    logic [31:0] held_res;
    logic stable_ok;

    initial begin
        //        chk   cres  rst   iv    op     exv   res            wbr   we     d0              d1              e_ctrl          e_res          e_q0            e_q1
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0,         1'b0, 2'b00, 34'h0,          34'h0,          C_IDLE,         32'h0,         34'h0,          34'h0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0,         1'b0, 2'b00, 34'h0,          34'h0,          C_IDLE,         32'h0,         34'h0,          34'h0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 32'hDEAD_BEEF, 1'b0, 2'b01, 34'h1_1111_1111, 34'h0,         C_IDLE,         32'h0,         34'h0,          34'h0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0,         1'b0, 2'b00, 34'h0,          34'h0,          C_IDLE,         32'h0,         34'h0,          34'h0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 32'h1234_5678, 1'b0, 2'b00, 34'h0,          34'h0,          10'b0100001010, 32'h0,         34'h0,          34'h0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0,         1'b1, 2'b00, 34'h0,          34'h0,          10'b1000000110, 32'h1234_5678, 34'h0,          34'h0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0,         1'b0, 2'b00, 34'h0,          34'h0,          C_IDLE,         32'h0,         34'h0,          34'h0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0,         1'b0, 2'b10, 34'h0,          34'h2_AAAA_5555, 10'b0110101010, 32'h0,        34'h0,          34'h0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 32'hCAFE_F00D, 1'b0, 2'b01, 34'h42,         34'h0,          10'b0010101010, 32'h0,         34'h0,          34'h2_AAAA_5555};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0,         1'b0, 2'b11, 34'h3_FFFF_FFFF, 34'h1_2345_6789, 10'b0000100110, 32'hCAFE_F00D, 34'h42,     34'h2_AAAA_5555};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0,         1'b1, 2'b00, 34'h0,          34'h0,          10'b1000100110, 32'hCAFE_F00D, 34'h42,         34'h2_AAAA_5555};

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].rst, vecs[i].iv, vecs[i].op, vecs[i].exv, vecs[i].res, vecs[i].wbr,
                  vecs[i].we, vecs[i].d0, vecs[i].d1);
            @(negedge clk_i);
            if (vecs[i].chk) begin
                check($sformatf("vec%0d ctrl", i), 64'(ctrl()), 64'(vecs[i].e_ctrl));
                check($sformatf("vec%0d imd0", i), 64'(imd_val_q_o[0]), 64'(vecs[i].e_q0));
                check($sformatf("vec%0d imd1", i), 64'(imd_val_q_o[1]), 64'(vecs[i].e_q1));
                if (vecs[i].chk_res)
                    check($sformatf("vec%0d wb_result", i), 64'(wb_result_o), 64'(vecs[i].e_res));
            end
            to_next_cycle();
        end

        // Back in IDLE: intermediate values survive the op boundary
        drive(0, 0, 2'b00, 0, 32'h0, 0, 2'b00, 34'h0, 34'h0);
        @(negedge clk_i);
        check("idle after wb ctrl", 64'(ctrl()), 64'(C_IDLE));
        check("imd0 kept across ops", 64'(imd_val_q_o[0]), 64'h42);
        check("imd1 kept across ops", 64'(imd_val_q_o[1]), 64'h2_AAAA_5555);
        to_next_cycle();

        // DIV taking 37 EXEC cycles, imd write on its first cycle
        drive(0, 1, 2'b11, 0, 32'h0, 0, 2'b00, 34'h0, 34'h0);
        to_next_cycle();
        cnt = 0;
        for (int n = 1; n <= 37; n++) begin
            drive(0, 0, 2'b00, n == 37, 32'h0BAD_F00D, 0, (n == 1) ? 2'b11 : 2'b00,
                  34'h3_0000_0001, 34'h0_FFFF_FFFF);
            @(negedge clk_i);
            if (div_en_o) cnt++;
            to_next_cycle();
        end
        drive(0, 0, 2'b00, 0, 32'h0, 0, 2'b00, 34'h0, 34'h0);
        @(negedge clk_i);
        check("div_en cycles", 64'(cnt), 64'd37);
        check("div wb ctrl", 64'(ctrl()), 64'b0000010110);
        check("div wb_result", 64'(wb_result_o), 64'h0BAD_F00D);
        check("div imd0", 64'(imd_val_q_o[0]), 64'h3_0000_0001);
        check("div imd1", 64'(imd_val_q_o[1]), 64'h0_FFFF_FFFF);
        to_next_cycle();

        // WB stall for 5 cycles, then back-to-back MUL issue
        held_res = wb_result_o;
        stable_ok = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk_i);
            if (wb_result_o !== held_res || issue_ready_o !== 1'b0 || wb_valid_o !== 1'b1)
                stable_ok = 1'b0;
            to_next_cycle();
        end
        check("wb stall stable", 64'(stable_ok), 64'd1);
        drive(0, 1, 2'b10, 0, 32'h0, 1, 2'b00, 34'h0, 34'h0);
        @(negedge clk_i);
        check("wb ready handoff ctrl", 64'(ctrl()), 64'b1000010110);
        to_next_cycle();
        drive(0, 0, 2'b00, 0, 32'h0, 0, 2'b11, 34'h1_0000_0007, 34'h2_0000_0009);
        @(negedge clk_i);
        check("b2b mul first ctrl", 64'(ctrl()), 64'b0110101010);
        to_next_cycle();

        // Reset during the third EXEC cycle of the MUL
        drive(0, 0, 2'b00, 0, 32'h0, 0, 2'b00, 34'h0, 34'h0);
        @(negedge clk_i);
        check("mul exec2 imd0", 64'(imd_val_q_o[0]), 64'h1_0000_0007);
        to_next_cycle();
        drive(1, 0, 2'b00, 0, 32'h0, 0, 2'b00, 34'h0, 34'h0);
        @(negedge clk_i);
        check("mul exec3 ctrl", 64'(ctrl()), 64'b0010101010);
        to_next_cycle();
        drive(0, 0, 2'b00, 0, 32'h0, 0, 2'b00, 34'h0, 34'h0);
        @(negedge clk_i);
        check("post-reset ctrl", 64'(ctrl()), 64'(C_IDLE));
        check("post-reset imd0", 64'(imd_val_q_o[0]), 64'h0);
        check("post-reset imd1", 64'(imd_val_q_o[1]), 64'h0);
        check("post-reset wb_result", 64'(wb_result_o), 64'h0);
        to_next_cycle();
        @(negedge clk_i);
        check("no wb after reset", 64'(wb_valid_o), 64'd0);
        to_next_cycle();

        // ALU multi-cycle op whose result never arrives
        drive(0, 1, 2'b01, 0, 32'h5555_AAAA, 0, 2'b00, 34'h0, 34'h0);
        to_next_cycle();
        drive(0, 0, 2'b00, 0, 32'h5555_AAAA, 0, 2'b00, 34'h0, 34'h0);
        cnt = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk_i);
            if (wb_valid_o) break;
            if (multdiv_ready_id_o) cnt++;
            to_next_cycle();
        end
`ifdef IBEX_EX_ISSUE_TIMEOUT_EN
        check("timeout exec cycles", 64'(cnt), 64'd64);
        check("timeout wb_valid", 64'(wb_valid_o), 64'd1);
        check("timeout wb_err", 64'(wb_err_o), 64'd1);
        check("timeout wb_result", 64'(wb_result_o), 64'h0);
`else
        @(negedge clk_i);
        check("no timeout exec cycles", 64'(cnt), 64'd200);
        check("no timeout ctrl", 64'(ctrl()), 64'b0000001010);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
